// File: rtl/pipe_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_trace_monitor
//  Brief    : ID-stage PC/instruction trace buffer with counters, halt
//             detection, watchdog and indexed read-back port.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_trace_monitor #(
    parameter int                  PC_W        = 32,
    parameter int                  INSTR_W     = 32,
    parameter int                  DEPTH       = 16,
    parameter int                  HALT_REPEAT = 4,
    parameter logic [INSTR_W-1:0]  HALT_INSTR  = 32'h0000000C,
    parameter int                  MAX_CYCLES  = 100000,
    parameter int                  CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       trace_valid,
    input  logic [PC_W-1:0]            trace_pc,
    input  logic [INSTR_W-1:0]         trace_instr,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       rd_valid,
    output logic                       rd_hit,
    output logic [PC_W-1:0]            rd_pc,
    output logic [INSTR_W-1:0]         rd_instr,
    output logic                       done,
    output logic                       timed_out,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           retired_cnt,
    output logic [$clog2(DEPTH):0]     fill_cnt
);

    localparam int                 c_aw        = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_full      = (c_aw+1)'(DEPTH);
    localparam logic [CNT_W-1:0]   c_cyc_last  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_halt_rep  = CNT_W'(HALT_REPEAT);

    localparam logic [1:0] c_st_run     = 2'd0;
    localparam logic [1:0] c_st_halted  = 2'd1;
    localparam logic [1:0] c_st_timeout = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_run;
    logic                w_wr_en;
    logic                w_halt;
    logic                w_timeout;

    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw:0]       r_fill;
    logic [CNT_W-1:0]    r_cycle;
    logic [CNT_W-1:0]    r_retired;
    logic [CNT_W-1:0]    r_repeat;
    logic [CNT_W-1:0]    w_repeat_next;
    logic [PC_W-1:0]     r_last_pc;

    logic [PC_W-1:0]     r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0]  r_mem_instr [DEPTH];

    logic [c_aw-1:0]     w_rd_addr;
    logic                w_rd_hit;
    logic                r_rd_valid;
    logic                r_rd_hit;
    logic [PC_W-1:0]     r_rd_pc;
    logic [INSTR_W-1:0]  r_rd_instr;

    // The first valid sample after reset never counts as a repeat.
    always_comb begin
        w_repeat_next = CNT_W'(1);
        if ((r_retired != '0) && (trace_pc == r_last_pc))
            w_repeat_next = (r_repeat == '1) ? r_repeat : r_repeat + CNT_W'(1);
    end

    assign w_wr_en   = w_run & trace_valid;
    assign w_halt    = w_wr_en & ((trace_instr == HALT_INSTR) || (w_repeat_next == c_halt_rep));
    assign w_timeout = w_run & (r_cycle == c_cyc_last) & ~w_halt;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= c_st_run;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_run: begin
                if (w_halt)         w_state_next = c_st_halted;
                else if (w_timeout) w_state_next = c_st_timeout;
            end
            default: w_state_next = r_state;
        endcase
    end

    always_comb begin
        w_run     = (r_state == c_st_run);
        done      = (r_state == c_st_halted);
        timed_out = (r_state == c_st_timeout);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_cycle   <= '0;
            r_retired <= '0;
            r_repeat  <= '0;
            r_last_pc <= '0;
        end else if (w_run) begin
            if (r_cycle != '1) r_cycle <= r_cycle + CNT_W'(1);
            if (trace_valid) begin
                r_wr_ptr  <= r_wr_ptr + c_aw'(1);
                if (r_fill != c_full)  r_fill    <= r_fill + (c_aw+1)'(1);
                if (r_retired != '1)   r_retired <= r_retired + CNT_W'(1);
                r_repeat  <= w_repeat_next;
                r_last_pc <= trace_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]    <= trace_pc;
            r_mem_instr[r_wr_ptr] <= trace_instr;
        end
    end

    // Index 0 maps to the oldest entry; pre-write pointers give old-data reads.
    assign w_rd_addr = r_wr_ptr - r_fill[c_aw-1:0] + rd_idx;
    assign w_rd_hit  = ({1'b0, rd_idx} < r_fill);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_hit   <= w_rd_hit;
                r_rd_pc    <= w_rd_hit ? r_mem_pc[w_rd_addr]    : '0;
                r_rd_instr <= w_rd_hit ? r_mem_instr[w_rd_addr] : '0;
            end
        end
    end

    assign rd_valid    = r_rd_valid;
    assign rd_hit      = r_rd_hit;
    assign rd_pc       = r_rd_pc;
    assign rd_instr    = r_rd_instr;
    assign cycle_cnt   = r_cycle;
    assign retired_cnt = r_retired;
    assign fill_cnt    = r_fill;

endmodule
`default_nettype wire
